// File: rtl/booth_mult_arbiter_pkg.sv
// rtl/booth_mult_arbiter_pkg.sv - shared types and default constants for the Booth multiplier arbiter
// Purpose: FSM state encoding and default parameter values used by
// booth_mult_arbiter and rr_priority_picker.
// Ports: none (package).
package booth_mult_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_LAUNCH  = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_DELIVER = 2'd3
  } Arb_State_t;

  localparam int ARB_N_REQ   = 4;
  localparam int ARB_DW      = 16;
  localparam int ARB_TIMEOUT = 64;

endpackage

// File: rtl/booth_mult_arbiter_rr_priority_picker.sv
// rtl/booth_mult_arbiter_rr_priority_picker.sv - round-robin rotate-and-priority-encode
// Purpose: combinational picker. Returns the first set request bit found
// scanning upward from rr_ptr+1, wrapping past N_REQ-1 back to 0.
// Ports:
//   req     in  N_REQ            request vector
//   rr_ptr  in  $clog2(N_REQ)    index of the most recent owner
//   any_req out 1                at least one request set
//   winner  out $clog2(N_REQ)    selected requester (0 when any_req is low)
module rr_priority_picker
  import booth_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     any_req,
  output logic [$clog2(N_REQ)-1:0] winner
);

  localparam int IW = $clog2(N_REQ);

  assign any_req = |req;

  // Walk candidates from the farthest (rr_ptr itself) to the nearest
  // (rr_ptr+1); the last hit written is the nearest, i.e. highest priority.
  always_comb begin
    int cand;
    cand   = 0;
    winner = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req[cand[IW-1:0]]) winner = cand[IW-1:0];
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - round-robin arbiter sharing one Booth multiplier among requesters
// Purpose: grants one requester at a time, latches its operands, sequences
// the multiplier start/ready handshake, returns the product with a done
// pulse, and flags a multiplier that never answers.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req               per-requester level request, held until grant
//   op_a, op_b        per-requester operands
//   grant             one-hot pulse, operands accepted (with mult_start)
//   done              one-hot pulse, result_o valid for that requester
//   err               pulse with done when the watchdog expired
//   result_o          last delivered product (0 after a timeout)
//   mult_start        start pulse to the multiplier
//   mult_a, mult_b    latched operands, stable until the next grant
//   mult_ready        multiplier completion pulse (honoured only in WAIT)
//   mult_result       multiplier product, valid with mult_ready
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int N_REQ   = ARB_N_REQ,
  parameter int DW      = ARB_DW,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0][DW-1:0] op_a,
  input  logic [N_REQ-1:0][DW-1:0] op_b,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     err,
  output logic [2*DW-1:0]          result_o,
  output logic                     mult_start,
  output logic [DW-1:0]            mult_a,
  output logic [DW-1:0]            mult_b,
  input  logic                     mult_ready,
  input  logic [2*DW-1:0]          mult_result
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  Arb_State_t      state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   wd_cnt;
  logic            any_req;
  logic [IW-1:0]   winner;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  // Outputs are registered: grant/mult_start are loaded on the edge into
  // LAUNCH, done/err/result_o on the edge into DELIVER, so each is visible
  // exactly during the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      rr_ptr     <= IW'(N_REQ - 1);
      wd_cnt     <= '0;
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      result_o   <= '0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
    end else begin
      grant      <= '0;
      done       <= '0;
      err        <= 1'b0;
      mult_start <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            mult_a     <= op_a[winner];
            mult_b     <= op_b[winner];
            owner      <= winner;
            rr_ptr     <= winner;
            grant      <= N_REQ'(1) << winner;
            mult_start <= 1'b1;
            state      <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // A ready arriving on the last watchdog cycle still wins.
          if (mult_ready) begin
            result_o <= mult_result;
            done     <= N_REQ'(1) << owner;
            state    <= ARB_DELIVER;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            result_o <= '0;
            err      <= 1'b1;
            done     <= N_REQ'(1) << owner;
            state    <= ARB_DELIVER;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        ARB_DELIVER: begin
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb/tb_booth_mult_arbiter.sv - self-checking bench for booth_mult_arbiter
module tb_booth_mult_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0][DW-1:0] op_a;
  logic [N-1:0][DW-1:0] op_b;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              err;
  logic [2*DW-1:0]   result_o;
  logic              mult_start;
  logic [DW-1:0]     mult_a;
  logic [DW-1:0]     mult_b;
  wire               mult_ready;
  logic [2*DW-1:0]   mult_result;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int exp_last = N - 1;

  // multiplier model controls
  logic        model_ready;
  logic        spur_ready;
  logic        mult_hang;
  logic        model_busy;
  int          model_lat;
  int          model_cnt;
  logic signed [31:0] pa, pb;

  booth_mult_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .result_o    (result_o),
    .mult_start  (mult_start),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_ready  (mult_ready),
    .mult_result (mult_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mult_ready = model_ready | spur_ready;

  // Multiplier model: ready pulses model_lat cycles after the start cycle.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      model_ready = 1'b0;
      model_busy  = 1'b0;
      model_cnt   = 0;
      mult_result = '0;
    end else begin
      model_ready = 1'b0;
      if (mult_start) begin
        model_busy = !mult_hang;
        model_cnt  = model_lat;
        pa = $signed(mult_a);
        pb = $signed(mult_b);
      end else if (model_busy) begin
        model_cnt--;
        if (model_cnt == 0) begin
          model_busy  = 1'b0;
          model_ready = 1'b1;
          mult_result = pa * pb;
        end
      end
    end
  end

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 32'(x * y);
  endfunction

  // First set bit scanning upward from last+1 with wrap.
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_sig(input bit want_done, input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((want_done ? done : grant) != '0) begin
        ok = 1'b1;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_last = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; op_a = '0; op_b = '0;
    spur_ready = 1'b0; mult_hang = 1'b0; model_lat = 5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({grant, done, err, mult_start} !== '0)
      $display("FAIL reset_ctrl: got %b expected 0", {grant, done, err, mult_start});
    else n_pass++;
    n_checks++;
    if (result_o !== '0) $display("FAIL reset_result: got %h expected 0", result_o);
    else n_pass++;
    n_checks++;
    if ({mult_a, mult_b} !== '0) $display("FAIL reset_operands: got %h expected 0", {mult_a, mult_b});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int g_at, d_at;
    op_a[1] = 16'd7; op_b[1] = 16'hFFFD; model_lat = 18; req = 4'b0010;
    wait_sig(0, 10, ok, g_at);
    req = '0;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL single_grant: got %b expected 0010", grant);
    else n_pass++;
    n_checks++;
    if (mult_start !== 1'b1) $display("FAIL single_start: got %b expected 1", mult_start);
    else n_pass++;
    exp_last = 1;
    wait_sig(1, 40, ok, d_at);
    n_checks++;
    if (!ok || done !== 4'b0010) $display("FAIL single_done: got %b expected 0010", done);
    else n_pass++;
    n_checks++;
    if (result_o !== 32'hFFFF_FFEB || err !== 1'b0)
      $display("FAIL single_result: got %h err %b expected ffffffeb err 0", result_o, err);
    else n_pass++;
    n_checks++;
    if (d_at - g_at != 19) $display("FAIL single_latency: got %0d expected 19", d_at - g_at);
    else n_pass++;
  endtask

  task automatic test_fairness();
    bit ok; int at, e;
    logic [15:0] ea, eb;
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
    end
    req = '1;
    for (int n = 0; n < 8; n++) begin
      model_lat = $urandom_range(1, 12);
      wait_sig(0, 20, ok, at);
      e = pick(req, exp_last);
      n_checks++;
      if (!ok || grant !== 4'(1 << e)) $display("FAIL rr_grant op%0d: got %b expected idx %0d", n, grant, e);
      else n_pass++;
      ea = op_a[e]; eb = op_b[e];
      n_checks++;
      if (mult_a !== ea || mult_b !== eb)
        $display("FAIL rr_operands op%0d: got %h/%h expected %h/%h", n, mult_a, mult_b, ea, eb);
      else n_pass++;
      exp_last = e;
      op_a[e] = 16'($urandom); op_b[e] = 16'($urandom);
      wait_sig(1, 30, ok, at);
      n_checks++;
      if (!ok || done !== 4'(1 << e) || result_o !== prod(ea, eb) || mult_a !== ea)
        $display("FAIL rr_done op%0d: got %b %h expected idx %0d %h", n, done, result_o, e, prod(ea, eb));
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_back_to_back();
    bit ok; int at, d_at, e;
    logic [15:0] ea, eb;
    op_a[2] = 16'($urandom); op_b[2] = 16'($urandom);
    op_a[3] = 16'($urandom); op_b[3] = 16'($urandom);
    model_lat = $urandom_range(1, 8);
    req = 4'b1100;
    wait_sig(0, 10, ok, at);
    e = pick(4'b1100, exp_last);
    n_checks++;
    if (!ok || grant !== 4'(1 << e)) $display("FAIL b2b_first: got %b expected idx %0d", grant, e);
    else n_pass++;
    req = 4'b1000;
    exp_last = e;
    wait_sig(1, 20, ok, d_at);
    n_checks++;
    if (!ok || done !== 4'b0100) $display("FAIL b2b_done2: got %b expected 0100", done);
    else n_pass++;
    ea = op_a[3]; eb = op_b[3];
    wait_sig(0, 10, ok, at);
    n_checks++;
    if (!ok || grant !== 4'b1000) $display("FAIL b2b_second: got %b expected 1000", grant);
    else n_pass++;
    n_checks++;
    if (at - d_at != 2) $display("FAIL b2b_gap: got %0d expected 2", at - d_at);
    else n_pass++;
    req = '0;
    exp_last = 3;
    wait_sig(1, 20, ok, at);
    n_checks++;
    if (!ok || done !== 4'b1000 || result_o !== prod(ea, eb))
      $display("FAIL b2b_result: got %b %h expected 1000 %h", done, result_o, prod(ea, eb));
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok, early; int g_at, d_at;
    mult_hang = 1'b1;
    req = 4'b0001;
    wait_sig(0, 10, ok, g_at);
    req = '0;
    n_checks++;
    if (!ok || grant !== 4'b0001) $display("FAIL to_grant: got %b expected 0001", grant);
    else n_pass++;
    exp_last = 0;
    early = 1'b0;
    d_at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done != '0) begin d_at = cyc; break; end
      if (err) early = 1'b1;
    end
    n_checks++;
    if (d_at - g_at != 65 || early) $display("FAIL to_latency: got %0d expected 65", d_at - g_at);
    else n_pass++;
    n_checks++;
    if (done !== 4'b0001 || err !== 1'b1 || result_o !== '0)
      $display("FAIL to_deliver: got done %b err %b res %h expected 0001 1 0", done, err, result_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== '0 || err !== 1'b0) $display("FAIL to_release: got done %b err %b expected 0 0", done, err);
    else n_pass++;
    mult_hang = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, seen; int at;
    logic [15:0] ea, eb;
    op_a[1] = 16'($urandom) | 16'h1; op_b[1] = 16'($urandom) | 16'h1;
    model_lat = 30;
    req = 4'b0010;
    wait_sig(0, 10, ok, at);
    req = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({grant, done, err, mult_start} !== '0 || result_o !== '0 || {mult_a, mult_b} !== '0)
      $display("FAIL rst_wait_outputs: got %b %h %h expected 0", {grant, done, err, mult_start}, result_o, {mult_a, mult_b});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_last = N - 1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done != '0 || grant != '0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL rst_wait_quiet: got activity expected none");
    else n_pass++;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 16'($urandom); op_b[i] = 16'($urandom);
    end
    ea = op_a[0]; eb = op_b[0];
    model_lat = 4;
    req = '1;
    wait_sig(0, 10, ok, at);
    req = '0;
    n_checks++;
    if (!ok || grant !== 4'(1 << pick(4'b1111, exp_last)))
      $display("FAIL rst_wait_first: got %b expected 0001", grant);
    else n_pass++;
    exp_last = 0;
    wait_sig(1, 20, ok, at);
    n_checks++;
    if (!ok || done !== 4'b0001 || result_o !== prod(ea, eb))
      $display("FAIL rst_wait_result: got %b %h expected 0001 %h", done, result_o, prod(ea, eb));
    else n_pass++;
  endtask

  task automatic test_spurious();
    bit ok, seen; int at;
    logic [31:0] held;
    held = result_o;
    seen = 1'b0;
    @(negedge clk);
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done != '0 || grant != '0 || err || result_o !== held) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL spur_idle: got activity result %h expected none held %h", result_o, held);
    else n_pass++;
    model_lat = 15;
    req = 4'b0001;
    wait_sig(0, 10, ok, at);
    req = '0;
    exp_last = 0;
    repeat (3) @(negedge clk);
    req = 4'b1000;
    repeat (4) @(negedge clk);
    req = '0;
    wait_sig(1, 30, ok, at);
    n_checks++;
    if (!ok || done !== 4'b0001) $display("FAIL spur_owner: got %b expected 0001", done);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant != '0) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL spur_dropped_req: got grant expected none");
    else n_pass++;
    model_lat = 3;
    req = 4'b1010;
    wait_sig(0, 10, ok, at);
    req = '0;
    n_checks++;
    if (!ok || grant !== 4'(1 << pick(4'b1010, exp_last)))
      $display("FAIL spur_next: got %b expected 0010", grant);
    else n_pass++;
    wait_sig(1, 20, ok, at);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    test_spurious();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
